// File: rtl/m92_sprite_dma.sv
// m92_sprite_dma -- sprite list DMA engine for the M92 object pipeline.
//
// A CPU write to the sprite control window arms a transfer. During vertical
// blank the engine copies the active sprite entries (count * 4 words) from
// sprite RAM into the renderer's private list buffer, then pulses dma_done
// toward the interrupt controller.
//
// Optional feature macro: M92_SPRITE_DMA_CLEAR_EN
//   defined   : the whole WORDS buffer is written; words at or above the
//               latched length are written as zero to clear stale entries.
//   undefined : only the latched length is written; the rest is untouched.
//
// Ports:
//   CLK_32M, reset        clock, asynchronous active-high reset
//   sprite_control_memrq  CPU access to the sprite control window
//   MWR, A, DIN, BYTE_SEL CPU write strobe, word address [3:1], data, lanes
//   VBLK                  vertical blank
//   sprite_freeze         drops DMA triggers while high
//   src_addr / src_dout   sprite RAM read port (data one cycle after address)
//   dst_addr / dst_data / dst_we  list buffer write port
//   entry_count           entry count latched at transfer start
//   dma_busy              transfer pending or active
//   dma_done              one-cycle completion pulse
module m92_sprite_dma #(
  parameter int WORDS = 1024
) (
  input  logic        CLK_32M,
  input  logic        reset,
  input  logic        sprite_control_memrq,
  input  logic        MWR,
  input  logic [2:0]  A,
  input  logic [15:0] DIN,
  input  logic [1:0]  BYTE_SEL,
  input  logic        VBLK,
  input  logic        sprite_freeze,
  output logic [9:0]  src_addr,
  input  logic [15:0] src_dout,
  output logic [9:0]  dst_addr,
  output logic [15:0] dst_data,
  output logic        dst_we,
  output logic [7:0]  entry_count,
  output logic        dma_busy,
  output logic        dma_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [10:0] LAST_IDX = 11'(WORDS - 1);

  logic [2:0]  state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [7:0]  entry_q, entry_d;
  logic        retrig_q, retrig_d;
  logic [7:0]  count_q;
  logic        ctrl_q;
  logic        vld_p1_q;
  logic        fill_p1_q;
  logic [9:0]  waddr_p1_q;

  logic reg_wr, trig_ok, issue, xfer_end;
  logic unused_bits;

  assign reg_wr  = sprite_control_memrq & MWR & BYTE_SEL[0];
  assign trig_ok = reg_wr & (A == 3'd4) & ~sprite_freeze;

  // The source-half select has only one legal value, so ctrl_q never
  // steers the read address.
  assign unused_bits = ^{DIN[15:8], BYTE_SEL[1], ctrl_q};

`ifdef M92_SPRITE_DMA_CLEAR_EN
  assign issue    = (state_q == S_XFER);
  assign xfer_end = (cnt_q == LAST_IDX);
`else
  // The counter reaching len is a dead cycle with no issue, which makes the
  // zero-length transfer fall out without a special case.
  assign issue    = (state_q == S_XFER) && (cnt_q != len_q);
  assign xfer_end = (cnt_q == len_q);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    entry_d  = entry_q;
    retrig_d = retrig_q;
    case (state_q)
      S_IDLE: if (trig_ok) state_d = S_WAIT;
      S_WAIT: begin
        if (VBLK) begin
          len_d   = {1'b0, count_q, 2'b00};
          entry_d = count_q;
          cnt_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (xfer_end) state_d = S_FLUSH;
        else          cnt_d   = cnt_q + 11'd1;
        if (trig_ok) retrig_d = 1'b1;
      end
      S_FLUSH: begin
        state_d = S_DONE;
        if (trig_ok) retrig_d = 1'b1;
      end
      S_DONE: begin
        // A trigger landing in DONE itself re-arms immediately.
        state_d  = (retrig_q | trig_ok) ? S_WAIT : S_IDLE;
        retrig_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      entry_q  <= '0;
      retrig_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      entry_q  <= entry_d;
      retrig_q <= retrig_d;
    end
  end

  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ctrl_q  <= 1'b0;
    end else if (reg_wr) begin
      if (A == 3'd0) count_q <= DIN[7:0];
      if (A == 3'd2) ctrl_q  <= DIN[0];
    end
  end

  // ---- stage p0 -> p1: read issued, write lands when sprite RAM data returns
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      vld_p1_q   <= 1'b0;
      fill_p1_q  <= 1'b0;
      waddr_p1_q <= '0;
    end else begin
      vld_p1_q   <= issue;
      fill_p1_q  <= (cnt_q < len_q);
      waddr_p1_q <= cnt_q[9:0];
    end
  end

  assign src_addr    = cnt_q[9:0];
  assign dst_we      = vld_p1_q;
  assign dst_addr    = waddr_p1_q;
  assign dst_data    = (vld_p1_q && fill_p1_q) ? src_dout : 16'h0000;
  assign entry_count = entry_q;
  assign dma_done    = (state_q == S_DONE);
  assign dma_busy    = ((state_q != S_IDLE) && (state_q != S_DONE)) ||
                       ((state_q == S_DONE) && retrig_q);

endmodule

// File: tb/tb_m92_sprite_dma.sv
module tb_m92_sprite_dma;

`ifdef M92_SPRITE_DMA_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif
  localparam int WORDS = 1024;

  logic        CLK_32M = 1'b0;
  logic        reset = 1'b1;
  logic        sprite_control_memrq = 1'b0;
  logic        MWR = 1'b0;
  logic [2:0]  A = '0;
  logic [15:0] DIN = '0;
  logic [1:0]  BYTE_SEL = '0;
  logic        VBLK = 1'b0;
  logic        sprite_freeze = 1'b0;
  logic [9:0]  src_addr;
  logic [15:0] src_dout = '0;
  logic [9:0]  dst_addr;
  logic [15:0] dst_data;
  logic        dst_we;
  logic [7:0]  entry_count;
  logic        dma_busy;
  logic        dma_done;

  m92_sprite_dma #(.WORDS(WORDS)) dut (
    .CLK_32M(CLK_32M), .reset(reset),
    .sprite_control_memrq(sprite_control_memrq), .MWR(MWR), .A(A), .DIN(DIN),
    .BYTE_SEL(BYTE_SEL), .VBLK(VBLK), .sprite_freeze(sprite_freeze),
    .src_addr(src_addr), .src_dout(src_dout), .dst_addr(dst_addr),
    .dst_data(dst_data), .dst_we(dst_we), .entry_count(entry_count),
    .dma_busy(dma_busy), .dma_done(dma_done)
  );

  always #5 CLK_32M = ~CLK_32M;

  // Sprite RAM with one-cycle read latency, list buffer as seen by the renderer,
  // and the reference image of what that buffer should hold.
  logic [15:0] mem  [WORDS];
  logic [15:0] dbuf [WORDS];
  logic [15:0] ebuf [WORDS];

  int cyc = 0;
  always @(posedge CLK_32M) begin
    cyc <= cyc + 1;
    src_dout <= mem[src_addr];
  end

  int nvec = 0, nfail = 0;
  int nwr, ndone, gap_err, busy_drop, first_wr, last_wr;
  int done_at [4];
  bit busy_at [4];
  bit track_busy = 1'b0;
  logic [9:0] next_addr;

  always @(negedge CLK_32M) begin
    if (dst_we) begin
      if (nwr == 0) first_wr = cyc;
      last_wr = cyc;
      if (dst_addr !== next_addr) gap_err++;
      next_addr = dst_addr + 10'd1;
      dbuf[dst_addr] = dst_data;
      nwr++;
    end
    if (dma_done) begin
      if (ndone < 4) begin
        done_at[ndone] = cyc;
        busy_at[ndone] = dma_busy;
      end
      ndone++;
      next_addr = '0;
    end
    if (track_busy && !dma_busy && !dma_done) busy_drop++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_32M);
    #1;
  endtask

  task automatic clr_mon();
    nwr = 0; ndone = 0; gap_err = 0; busy_drop = 0;
    first_wr = -1; last_wr = -1; next_addr = '0;
    for (int i = 0; i < 4; i++) begin done_at[i] = -1; busy_at[i] = 1'b0; end
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [15:0] d);
    sprite_control_memrq = 1'b1; MWR = 1'b1; A = a; DIN = d; BYTE_SEL = 2'b01;
    tick();
    sprite_control_memrq = 1'b0; MWR = 1'b0; BYTE_SEL = 2'b00;
  endtask

  // Reference: words below len come from sprite RAM; with clear enabled the
  // rest of the buffer is zeroed, otherwise it keeps what it held.
  task automatic model_xfer(input int len);
    for (int i = 0; i < WORDS; i++)
      if (i < len) ebuf[i] = mem[i];
      else if (CLEAR) ebuf[i] = 16'h0000;
  endtask

  function automatic int n_writes(input int len);
    return CLEAR ? WORDS : len;
  endfunction

  // Trigger cycle to dma_done cycle, VBLK already high.
  function automatic int dur(input int len);
    return CLEAR ? WORDS + 3 : len + 4;
  endfunction

  task automatic chk_buf(input string tag);
    int bad = 0;
    for (int i = 0; i < WORDS; i++) if (dbuf[i] !== ebuf[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (ndone < n && k < budget) begin tick(); k++; end
    chk({tag, "_done_count"}, ndone, n);
  endtask

  task automatic chk_timing(input string tag, input int t, input int len);
    chk({tag, "_nwr"}, nwr, n_writes(len));
    if (n_writes(len) > 0) begin
      chk({tag, "_first_we"}, first_wr, t + 3);
      chk({tag, "_last_we"}, last_wr, t + 2 + n_writes(len));
    end
    chk({tag, "_done_cyc"}, done_at[0], t + dur(len));
    chk({tag, "_addr_gaps"}, gap_err, 0);
  endtask

  initial begin
    int t, v, c2, k, snap;
    for (int i = 0; i < WORDS; i++) begin
      mem[i]  = 16'h1000 + 16'(i);
      dbuf[i] = 16'hA5A5 ^ 16'(i);
      ebuf[i] = 16'hA5A5 ^ 16'(i);
    end
    clr_mon();
    repeat (3) tick();

    // reset state
    chk("rst_src_addr", int'(src_addr), 0);
    chk("rst_dst_addr", int'(dst_addr), 0);
    chk("rst_dst_data", int'(dst_data), 0);
    chk("rst_dst_we", int'(dst_we), 0);
    chk("rst_entry_count", int'(entry_count), 0);
    chk("rst_busy", int'(dma_busy), 0);
    chk("rst_done", int'(dma_done), 0);
    reset = 1'b0;
    tick();

    // count=2, ramp pattern, trigger with VBLK high
    VBLK = 1'b1;
    cpu_wr(3'd0, 16'hFF02);
    clr_mon();
    t = cyc;
    cpu_wr(3'd4, 16'($urandom));
    chk("t1_busy_t1", int'(dma_busy), 1);
    tick();
    chk("t1_src_addr_t2", int'(src_addr), 0);
    wait_done(1, 2000, "t1");
    chk_timing("t1", t, 8);
    chk("t1_entry_count", int'(entry_count), 2);
    model_xfer(8);
    chk_buf("t1_buffer");
    chk("t1_idle_busy", int'(dma_busy), 0);

    // trigger outside VBLK, raise VBLK 500 cycles later
    for (int i = 0; i < WORDS; i++) mem[i] = 16'($urandom);
    VBLK = 1'b0;
    c2 = $urandom_range(1, 255);
    cpu_wr(3'd0, 16'(c2));
    clr_mon();
    cpu_wr(3'd4, 16'h0000);
    track_busy = 1'b1;
    repeat (500) tick();
    chk("t2_no_we_before_vblk", nwr, 0);
    VBLK = 1'b1;
    v = cyc;
    wait_done(1, 2000, "t2");
    track_busy = 1'b0;
    chk("t2_busy_held", busy_drop, 0);
    chk("t2_first_we", first_wr, v + 2);
    chk("t2_done_cyc", done_at[0], v + dur(4 * c2) - 1);
    chk("t2_nwr", nwr, n_writes(4 * c2));
    chk("t2_entry_count", int'(entry_count), c2);
    model_xfer(4 * c2);
    chk_buf("t2_buffer");

    // count=255, count rewrite and re-trigger mid transfer
    for (int i = 0; i < WORDS; i++) mem[i] = 16'($urandom);
    cpu_wr(3'd0, 16'h00FF);
    cpu_wr(3'd2, 16'h0001);
    clr_mon();
    t = cyc;
    cpu_wr(3'd4, 16'h1234);
    track_busy = 1'b1;
    k = 0;
    while (nwr < 300 && k < 5000) begin tick(); k++; end
    chk("t3_reach_word300", int'(nwr >= 300), 1);
    c2 = $urandom_range(0, 255);
    cpu_wr(3'd0, 16'(c2));
    chk("t3_entry_count_stable", int'(entry_count), 255);
    cpu_wr(3'd4, 16'h0000);
    wait_done(2, 4000, "t3");
    track_busy = 1'b0;
    chk("t3_first_done_cyc", done_at[0], t + dur(1020));
    chk("t3_busy_at_first_done", int'(busy_at[0]), 1);
    chk("t3_busy_at_second_done", int'(busy_at[1]), 0);
    chk("t3_busy_held", busy_drop, 0);
    chk("t3_second_done_cyc", done_at[1], done_at[0] + dur(4 * c2));
    chk("t3_nwr", nwr, n_writes(1020) + n_writes(4 * c2));
    chk("t3_addr_gaps", gap_err, 0);
    chk("t3_entry_count", int'(entry_count), c2);
    model_xfer(1020);
    model_xfer(4 * c2);
    chk_buf("t3_buffer");

    // trigger while frozen
    sprite_freeze = 1'b1;
    clr_mon();
    cpu_wr(3'd4, 16'h0000);
    chk("t4_frozen_busy", int'(dma_busy), 0);
    repeat (20) tick();
    chk("t4_frozen_nwr", nwr, 0);
    chk("t4_frozen_done", ndone, 0);
    sprite_freeze = 1'b0;

    // reset at word 300 of a transfer
    for (int i = 0; i < WORDS; i++) mem[i] = 16'($urandom);
    cpu_wr(3'd0, 16'h00FF);
    clr_mon();
    cpu_wr(3'd4, 16'h0000);
    k = 0;
    while (nwr < 300 && k < 5000) begin tick(); k++; end
    chk("t5_reach_word300", int'(nwr >= 300), 1);
    reset = 1'b1;
    #1;
    chk("t5_src_addr", int'(src_addr), 0);
    chk("t5_dst_addr", int'(dst_addr), 0);
    chk("t5_dst_data", int'(dst_data), 0);
    chk("t5_dst_we", int'(dst_we), 0);
    chk("t5_entry_count", int'(entry_count), 0);
    chk("t5_busy", int'(dma_busy), 0);
    chk("t5_done", int'(dma_done), 0);
    repeat (3) tick();
    reset = 1'b0;
    snap = nwr;
    repeat (100) tick();
    chk("t5_no_writes_after", nwr, snap);
    chk("t5_no_done_after", ndone, 0);
    chk("t5_idle_busy", int'(dma_busy), 0);
    for (int i = 0; i < WORDS; i++) ebuf[i] = dbuf[i];

    // count register cleared by reset: zero-entry transfer
    clr_mon();
    t = cyc;
    cpu_wr(3'd4, 16'h0000);
    wait_done(1, 2000, "t6");
    chk_timing("t6", t, 0);
    chk("t6_entry_count", int'(entry_count), 0);
    model_xfer(0);
    chk_buf("t6_buffer");
    tick();
    chk("t6_idle_busy", int'(dma_busy), 0);
    chk("t6_done_single", ndone, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
